// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier dispatch stage.
// The magnitude helper is used when MUL_DISPATCH_SIGNED_EN is defined.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } mul_disp_state_t;

  localparam int MUL_LEN_DEFAULT   = 32;
  localparam int MUL_DEPTH_DEFAULT = 4;
  localparam int MUL_MAX_LEN       = 64;

  // Magnitude of a width-bit two's-complement value held in the low bits;
  // the most negative value maps onto its unsigned magnitude.
  function automatic logic [MUL_MAX_LEN-1:0] twos_magnitude(
    input logic [MUL_MAX_LEN-1:0] value,
    input int                     width
  );
    logic [MUL_MAX_LEN-1:0] mask;
    logic [MUL_MAX_LEN-1:0] neg;
    mask = (width >= MUL_MAX_LEN) ? '1 : ((64'd1 << width) - 64'd1);
    neg  = (~value + 64'd1) & mask;
    return value[6'(width - 1)] ? neg : (value & mask);
  endfunction

endpackage

// File: rtl/mul_operand_fifo.sv
// Small power-of-two FIFO buffering operand pairs ahead of the multiplier.
// Pointers wrap naturally; full/empty come from the registered count.
module mul_operand_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mul_dispatch.sv
// Issues buffered operand pairs to a sequential multiplier and returns products
// on a valid/ready port. Define MUL_DISPATCH_SIGNED_EN for two's-complement mode.
module mul_dispatch
  import mul_pkg::*;
#(
  parameter int LEN   = MUL_LEN_DEFAULT,
  parameter int DEPTH = MUL_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN-1:0]   in_a,
  input  logic [LEN-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*LEN-1:0] out_product,
  output logic             mul_start,
  output logic [LEN-1:0]   mul_multiplicand,
  output logic [LEN-1:0]   mul_multiplier,
  input  logic [2*LEN-1:0] mul_product,
  input  logic             mul_finish,
  output logic             busy
);

  mul_disp_state_t      state_q;
  logic                 out_valid_q;
  logic [2*LEN-1:0]     out_product_q;
  logic                 mul_start_q;
  logic [LEN-1:0]       mcand_q;
  logic [LEN-1:0]       mplier_q;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [2*LEN-1:0]     fifo_rd_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [LEN-1:0]       a_pop;
  logic [LEN-1:0]       b_pop;
  logic [LEN-1:0]       a_mag;
  logic [LEN-1:0]       b_mag;
  logic [2*LEN-1:0]     prod_fix;

  mul_operand_fifo #(
    .WIDTH (2*LEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_valid),
    .push_data_i ({in_a, in_b}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign a_pop    = fifo_rd_data[2*LEN-1:LEN];
  assign b_pop    = fifo_rd_data[LEN-1:0];

`ifdef MUL_DISPATCH_SIGNED_EN
  logic sign_q;
  assign a_mag    = LEN'(twos_magnitude(64'(a_pop), LEN));
  assign b_mag    = LEN'(twos_magnitude(64'(b_pop), LEN));
  assign prod_fix = sign_q ? (~mul_product + (2*LEN)'(1)) : mul_product;
`else
  assign a_mag    = a_pop;
  assign b_mag    = b_pop;
  assign prod_fix = mul_product;
`endif

  // One operation in flight: a finish pulse only counts while in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      mul_start_q   <= 1'b0;
      mcand_q       <= '0;
      mplier_q      <= '0;
`ifdef MUL_DISPATCH_SIGNED_EN
      sign_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            mcand_q     <= a_mag;
            mplier_q    <= b_mag;
`ifdef MUL_DISPATCH_SIGNED_EN
            sign_q      <= a_pop[LEN-1] ^ b_pop[LEN-1];
`endif
            mul_start_q <= 1'b1;
            state_q     <= LAUNCH;
          end
        end
        LAUNCH: begin
          mul_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (mul_finish) begin
            out_product_q <= prod_fix;
            out_valid_q   <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid        = out_valid_q;
  assign out_product      = out_product_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplicand = mcand_q;
  assign mul_multiplier   = mplier_q;
  assign busy             = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mul_dispatch.sv
// Scoreboard bench for mul_dispatch with a behavioural multiplier model.
// Honours MUL_DISPATCH_SIGNED_EN in its reference model.
module tb_mul_dispatch;

  localparam int LEN   = 8;
  localparam int DEPTH = 4;
  localparam int PW    = 2 * LEN;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [LEN-1:0] in_a = '0;
  logic [LEN-1:0] in_b = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [PW-1:0]  out_product;
  logic           mul_start;
  logic [LEN-1:0] mul_multiplicand;
  logic [LEN-1:0] mul_multiplier;
  logic [PW-1:0]  mul_product;
  logic           mul_finish;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] expProdQ[$];
  logic [PW-1:0] expOpQ[$];

  always #5 clk = ~clk;

  mul_dispatch #(
    .LEN   (LEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_finish       (mul_finish),
    .busy             (busy)
  );

  // Reference: plain arithmetic on the operand values as the user sees them.
  function automatic logic [PW-1:0] refProduct(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
`ifdef MUL_DISPATCH_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return PW'(sa * sb);
`else
    return PW'(longint'(a) * longint'(b));
`endif
  endfunction

  function automatic logic [PW-1:0] refOperands(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
`ifdef MUL_DISPATCH_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    return {LEN'(sa), LEN'(sb)};
`else
    return {a, b};
`endif
  endfunction

  // Sequential multiplier stand-in: fixed or random latency after a start pulse.
  int            mulLatency = 8;
  int            modelCnt;
  logic          modelFinish;
  logic [PW-1:0] modelProduct;
  logic          strayFinish = 1'b0;
  logic [PW-1:0] strayProduct = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      modelCnt     <= 0;
      modelFinish  <= 1'b0;
      modelProduct <= '0;
    end else begin
      modelFinish <= 1'b0;
      if (mul_start) begin
        modelCnt     <= (mulLatency == 0) ? int'($urandom_range(9, 2)) : mulLatency;
        modelProduct <= PW'(longint'(mul_multiplicand) * longint'(mul_multiplier));
      end else if (modelCnt != 0) begin
        modelCnt <= modelCnt - 1;
        if (modelCnt == 1) modelFinish <= 1'b1;
      end
    end
  end

  assign mul_finish  = modelFinish | strayFinish;
  assign mul_product = strayFinish ? strayProduct : modelProduct;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 500);
    if (!in_ready) begin
      checkOutput("pushTimeout", in_ready, 1);
    end else begin
      expProdQ.push_back(refProduct(a, b));
      expOpQ.push_back(refOperands(a, b));
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitValid();
    int guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("validTimeout", out_valid, 1);
    tick();
  endtask

  task automatic waitIdle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((busy || out_valid || expProdQ.size() != 0) && guard < 3000);
    checkOutput("drainBusy", busy, 0);
    checkOutput("drainPending", expProdQ.size(), 0);
    tick();
  endtask

  // Monitor: checks operands at each start pulse and products while valid.
  bit inFlight    = 1'b0;
  bit holdPending = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      expProdQ.delete();
      expOpQ.delete();
      inFlight    = 1'b0;
      holdPending = 1'b0;
    end else begin
      if (mul_start) begin
        if (inFlight) checkOutput("startWhileBusy", mul_start, 0);
        inFlight = 1'b1;
        if (expOpQ.size() == 0) checkOutput("startNoOperands", mul_start, 0);
        else checkOutput("mulOperands", {mul_multiplicand, mul_multiplier}, expOpQ.pop_front());
      end
      if (holdPending) checkOutput("holdValid", out_valid, 1);
      if (out_valid) begin
        if (expProdQ.size() == 0) begin
          checkOutput("unexpectedOutput", out_valid, 0);
        end else begin
          checkOutput("outProduct", out_product, expProdQ[0]);
          if (out_ready) void'(expProdQ.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        inFlight    = 1'b0;
        holdPending = 1'b0;
      end else if (out_valid) begin
        holdPending = 1'b1;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  logic [LEN-1:0] tableA [3] = '{8'hFD, 8'h80, 8'hF9};
  logic [LEN-1:0] tableB [3] = '{8'h05, 8'h80, 8'h00};

  initial begin
    int accepted;
    bit stimDone;
    logic [LEN-1:0] ra;
    logic [LEN-1:0] rb;

    repeat (2) tick();
    checkOutput("resetOutValid", out_valid, 0);
    checkOutput("resetOutProduct", out_product, 0);
    checkOutput("resetMulStart", mul_start, 0);
    checkOutput("resetOperands", {mul_multiplicand, mul_multiplier}, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetInReady", in_ready, 1);
    rst = 1'b1;
    tick();

    $display("[TB] directed 13*11 with backpressure");
    mulLatency = 8;
    out_ready  = 1'b0;
    applyStimulus(8'd13, 8'd11);
    waitValid();
    repeat (5) tick();
    checkOutput("directedProduct", out_product, 16'h008F);
    checkOutput("directedValidHeld", out_valid, 1);
    out_ready = 1'b1;
    waitIdle();

    $display("[TB] back-to-back pairs");
    applyStimulus(8'd255, 8'd255);
    applyStimulus(8'd0, 8'd77);
    waitIdle();

    $display("[TB] fill FIFO under backpressure");
    out_ready = 1'b0;
    accepted  = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = LEN'($urandom);
      in_b = LEN'($urandom);
      @(negedge clk);
      if (in_ready) begin
        expProdQ.push_back(refProduct(in_a, in_b));
        expOpQ.push_back(refOperands(in_a, in_b));
        accepted++;
      end
      tick();
    end
    in_valid = 1'b0;
    checkOutput("fillAccepted", accepted, 1 + DEPTH);
    checkOutput("fillInReady", in_ready, 0);
    out_ready = 1'b1;
    waitIdle();

    $display("[TB] sign boundary table and random traffic");
    mulLatency = 0;
    stimDone   = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(tableA[i], tableB[i]);
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(3, 0)) tick();
          applyStimulus(LEN'($urandom), LEN'($urandom));
        end
        stimDone = 1'b1;
      end
      begin
        while (!stimDone) begin
          out_ready = 1'($urandom_range(1, 0));
          tick();
        end
      end
    join
    out_ready = 1'b1;
    waitIdle();

    $display("[TB] stray finish pulses while holding output");
    mulLatency = 5;
    out_ready  = 1'b0;
    ra = LEN'($urandom);
    rb = LEN'($urandom);
    applyStimulus(ra, rb);
    waitValid();
    for (int i = 0; i < 20; i++) begin
      strayFinish  = 1'($urandom_range(1, 0));
      strayProduct = PW'($urandom);
      tick();
    end
    strayFinish = 1'b0;
    checkOutput("strayHoldProduct", out_product, refProduct(ra, rb));
    checkOutput("strayHoldValid", out_valid, 1);
    out_ready = 1'b1;
    waitIdle();

    $display("[TB] reset while waiting on the multiplier");
    mulLatency = 30;
    applyStimulus(8'd9, 8'd7);
    repeat (6) tick();
    checkOutput("preResetBusy", busy, 1);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    strayFinish  = 1'b1;
    strayProduct = 16'h1234;
    tick();
    strayFinish = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("postResetOutValid", out_valid, 0);
      checkOutput("postResetBusy", busy, 0);
      checkOutput("postResetInReady", in_ready, 1);
      checkOutput("postResetOutProduct", out_product, 0);
      checkOutput("postResetOperands", {mul_start, mul_multiplicand, mul_multiplier}, 0);
      tick();
    end

    checkOutput("finalQueueEmpty", expProdQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
